bsg_fifo_packet_gearbox: RTL
============================

Name: bsg_fifo_packet_gearbox

Overview:
- Sits directly downstream of the host AXI-Lite FIFO bridge (one instance per FIFO pair).
- TX path: gathers consecutive 32-bit words from the bridge's host-to-device FIFO output into one wide packet and presents it to the on-chip network endpoint.
- RX path: accepts wide packets from the endpoint and emits them as consecutive 32-bit words into the bridge's device-to-host FIFO input.
- Both paths are independent valid/ready pipelines with a single-packet buffer each.

Parameters:
- packet_width_p, 128, width of one network packet in bits; must be a multiple of 32 and at least 64.
- Local: word_width_lp = 32.
- Local: words_per_packet_lp = packet_width_p/32 (call it N).
- Local: word_cnt_width_lp = `BSG_SAFE_CLOG2(N)`.

Ports:
- clk_i, input, 1, block clock.
- reset_i, input, 1, reset; asynchronous, active-high.
- tx_word_v_i, input, 1, TX word valid (from bridge FIFO valid output).
- tx_word_i, input, 32, TX word data.
- tx_word_ready_o, output, 1, TX word accepted when v&ready (drives bridge FIFO ready input).
- tx_packet_v_o, output, 1, assembled packet valid.
- tx_packet_o, output, packet_width_p, assembled packet.
- tx_packet_ready_i, input, 1, endpoint accepts packet.
- rx_packet_v_i, input, 1, incoming packet valid.
- rx_packet_i, input, packet_width_p, incoming packet.
- rx_packet_ready_o, output, 1, packet accepted when v&ready.
- rx_word_v_o, output, 1, RX word valid (to bridge FIFO valid input).
- rx_word_o, output, 32, RX word data.
- rx_word_ready_i, input, 1, bridge FIFO ready.

Behaviour:
- Word order: word k occupies bits [32*k +: 32]. Word 0 is first in time and least significant, on both paths.
- Reset (async assert, released synchronously to clk_i):
  - Both FSMs go to their first state; both word counters = 0; packet registers = 0.
  - tx_packet_v_o=0, rx_word_v_o=0, tx_word_ready_o=1, rx_packet_ready_o=1.
  - Reset mid-packet discards any partial TX assembly and any undrained RX packet; no partial packet is ever emitted.
- TX FSM states: E_TX_COLLECT, E_TX_SEND.
  - E_TX_COLLECT: tx_word_ready_o=1. On each handshake, write tx_word_i into slot tx_cnt_r and increment tx_cnt_r.
  - On the handshake with tx_cnt_r==N-1: tx_cnt_r wraps to 0 and the FSM goes to E_TX_SEND.
  - Latency: tx_packet_v_o rises the cycle after the last word's handshake. It is registered; there is no combinational path from tx_word_v_i.
  - E_TX_SEND: tx_packet_v_o=1; tx_packet_o is held stable until the handshake.
  - tx_word_ready_o = tx_packet_ready_i (early release).
  - Packet handshake with no simultaneous word: go to E_TX_COLLECT.
  - Packet handshake with a simultaneous word: that word is written to slot 0, tx_cnt_r=1, and the FSM goes to E_TX_COLLECT. This gives full throughput of N words per N cycles.
  - No timeout: a partial packet waits indefinitely for its remaining words.
- RX FSM states: E_RX_IDLE, E_RX_SEND.
  - E_RX_IDLE: rx_packet_ready_o=1. On handshake, latch rx_packet_i, set rx_cnt_r=0, go to E_RX_SEND.
  - E_RX_SEND: rx_word_v_o=1, rx_word_o = slot rx_cnt_r. Each word handshake increments rx_cnt_r.
  - rx_packet_ready_o = (rx_cnt_r==N-1) & rx_word_ready_i. If a packet arrives on the last word's handshake, it is latched, rx_cnt_r=0, and the FSM stays in E_RX_SEND (back-to-back).
  - Last word handshake with no new packet: go to E_RX_IDLE.
  - rx_word_o is stable while rx_word_v_o=1 and ready=0.
- The TX and RX paths share no state. Simultaneous activity on both has no interaction.
- rx_packet_ready_o and tx_word_ready_o may depend combinationally on the downstream ready. No other input-to-output combinational paths exist.

Decomposition:
- Shared package bsg_fifo_packet_gearbox_pkg holds:
  - word width constant 32;
  - tx_state_e {E_TX_COLLECT=0, E_TX_SEND=1};
  - rx_state_e {E_RX_IDLE=0, E_RX_SEND=1}.
- One natural sub-module: bsg_packet_to_words (the RX serializer: packet register, counter, FSM), instantiated once.
- The TX assembler stays inline.
- Elaboration-time check: packet_width_p%32==0 and N>=2, else $error.

Test Plan (packet_width_p=128, N=4):
- TX basic: words 0x11,0x22,0x33,0x44 on consecutive cycles, tx_packet_ready_i=1 -> tx_packet_v_o high for one cycle, starting the cycle after 0x44; tx_packet_o=0x00000044_00000033_00000022_00000011.
- TX backpressure/throughput: tx_packet_ready_i=0 for 5 cycles with words continuously valid -> tx_word_ready_o=0 and the packet is held. Release -> next packet's word 0 is accepted in the release cycle. 8 words in -> exactly 2 correct packets, no word lost or duplicated.
- RX basic: packet 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, rx_word_ready_i=1 -> rx_word_o = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on 4 consecutive cycles. rx_packet_ready_o=1 on the 4th cycle, and a second packet offered then is accepted back-to-back.
- RX stall: rx_word_ready_i toggling 1,0,0,1,... -> words stay stable while stalled, emitted in order, and no new packet is accepted until the last word's handshake.
- Reset mid-operation: assert reset_i asynchronously after 2 TX words and 1 RX word -> outputs go to reset values immediately. After release, 4 fresh TX words yield a packet containing only the fresh words.
- Concurrent random: random valid/ready on all four interfaces for 10k cycles, scoreboarded -> TX packets equal grouped words and RX words equal split packets, in order.

Source files
------------

// File: rtl/bsg_fifo_packet_gearbox_pkg.sv
// Shared types and constants for the 32-bit word <-> wide packet gearbox.
package bsg_fifo_packet_gearbox_pkg;

  localparam int word_width_gp = 32;

  typedef enum logic {E_TX_COLLECT = 1'b0, E_TX_SEND = 1'b1} tx_state_e;
  typedef enum logic {E_RX_IDLE = 1'b0, E_RX_SEND = 1'b1} rx_state_e;

  // Counter width that stays at least one bit even for a single-entry range.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_packet_to_words.sv
// RX serializer: latches one wide packet and emits it word 0 first.
// A new packet is taken on the last word's handshake for back-to-back streaming.
module bsg_packet_to_words
  import bsg_fifo_packet_gearbox_pkg::*;
#(
  parameter int packet_width_p = 128
)
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      packet_v_i,
  input  logic [packet_width_p-1:0] packet_i,
  output logic                      packet_ready_o,
  output logic                      word_v_o,
  output logic [word_width_gp-1:0]  word_o,
  input  logic                      word_ready_i
);

  localparam int words_lp     = packet_width_p / word_width_gp;
  localparam int cnt_width_lp = safe_clog2(words_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(words_lp - 1);

  rx_state_e                 state_q;
  logic [cnt_width_lp-1:0]   cnt_q;
  logic [packet_width_p-1:0] pkt_q;
  logic                      last_word;

  assign last_word      = (state_q == E_RX_SEND) && (cnt_q == last_cnt_lp);
  assign packet_ready_o = (state_q == E_RX_IDLE) | (last_word & word_ready_i);
  assign word_v_o       = (state_q == E_RX_SEND);

  always_comb begin
    word_o = pkt_q[word_width_gp-1:0];
    for (int k = 1; k < words_lp; k++) begin
      if (cnt_q == cnt_width_lp'(k)) word_o = pkt_q[word_width_gp*k +: word_width_gp];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= E_RX_IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
    end else if (packet_v_i && packet_ready_o) begin
      // Covers both the idle accept and the back-to-back accept on the last word.
      pkt_q   <= packet_i;
      cnt_q   <= '0;
      state_q <= E_RX_SEND;
    end else if (word_v_o && word_ready_i) begin
      if (last_word) begin
        cnt_q   <= '0;
        state_q <= E_RX_IDLE;
      end else begin
        cnt_q <= cnt_q + cnt_width_lp'(1);
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_packet_gearbox.sv
// Word/packet gearbox: TX gathers N 32-bit words into one packet, RX splits packets into words.
// Each path is an independent valid/ready pipeline with a single-packet buffer.
module bsg_fifo_packet_gearbox
  import bsg_fifo_packet_gearbox_pkg::*;
#(
  parameter int packet_width_p = 128
)
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      tx_word_v_i,
  input  logic [word_width_gp-1:0]  tx_word_i,
  output logic                      tx_word_ready_o,
  output logic                      tx_packet_v_o,
  output logic [packet_width_p-1:0] tx_packet_o,
  input  logic                      tx_packet_ready_i,
  input  logic                      rx_packet_v_i,
  input  logic [packet_width_p-1:0] rx_packet_i,
  output logic                      rx_packet_ready_o,
  output logic                      rx_word_v_o,
  output logic [word_width_gp-1:0]  rx_word_o,
  input  logic                      rx_word_ready_i
);

  localparam int words_per_packet_lp = packet_width_p / word_width_gp;
  localparam int word_cnt_width_lp   = safe_clog2(words_per_packet_lp);
  localparam logic [word_cnt_width_lp-1:0] tx_last_lp = word_cnt_width_lp'(words_per_packet_lp - 1);

  generate
    if ((packet_width_p % word_width_gp) != 0 || words_per_packet_lp < 2) begin : g_bad_width
      $error("bsg_fifo_packet_gearbox: packet_width_p must be a multiple of 32 and at least 64");
    end
  endgenerate

  tx_state_e                    tx_state_q;
  logic [word_cnt_width_lp-1:0] tx_cnt_q;
  logic [packet_width_p-1:0]    tx_packet_q;
  logic                         tx_word_hs;
  logic                         tx_packet_hs;

  assign tx_packet_v_o   = (tx_state_q == E_TX_SEND);
  assign tx_packet_o     = tx_packet_q;
  // While a packet waits, a word may enter only in the cycle the packet leaves.
  assign tx_word_ready_o = (tx_state_q == E_TX_COLLECT) | tx_packet_ready_i;
  assign tx_word_hs      = tx_word_v_i & tx_word_ready_o;
  assign tx_packet_hs    = tx_packet_v_o & tx_packet_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q  <= E_TX_COLLECT;
      tx_cnt_q    <= '0;
      tx_packet_q <= '0;
    end else if (tx_state_q == E_TX_COLLECT) begin
      if (tx_word_hs) begin
        for (int k = 0; k < words_per_packet_lp; k++) begin
          if (tx_cnt_q == word_cnt_width_lp'(k)) tx_packet_q[word_width_gp*k +: word_width_gp] <= tx_word_i;
        end
        if (tx_cnt_q == tx_last_lp) begin
          tx_cnt_q   <= '0;
          tx_state_q <= E_TX_SEND;
        end else begin
          tx_cnt_q <= tx_cnt_q + word_cnt_width_lp'(1);
        end
      end
    end else if (tx_packet_hs) begin
      tx_state_q <= E_TX_COLLECT;
      if (tx_word_v_i) begin
        tx_packet_q[word_width_gp-1:0] <= tx_word_i;
        tx_cnt_q                       <= word_cnt_width_lp'(1);
      end
    end
  end

  bsg_packet_to_words #(
    .packet_width_p(packet_width_p)
  ) u_rx (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .packet_v_i    (rx_packet_v_i),
    .packet_i      (rx_packet_i),
    .packet_ready_o(rx_packet_ready_o),
    .word_v_o      (rx_word_v_o),
    .word_o        (rx_word_o),
    .word_ready_i  (rx_word_ready_i)
  );

endmodule
